// File: rtl/cmd_frame_if.sv
// Host / UART-facing signal bundle for cmd_frame_master.
//   master modport : the frame master (drives full, q_cnt, tx_byte, trmt,
//                    clr_rx_rdy, frm_snt, resp, resp_cmd, resp_vld,
//                    timeout, busy)
//   slave modport  : host + UART side (drives cmd_in, data_in, push,
//                    tx_done, rx_byte, rx_rdy)
interface cmd_frame_if #(
  parameter int DATA_BYTES = 2,
  parameter int QDEPTH     = 4
);
  logic [7:0]                cmd_in;
  logic [8*DATA_BYTES-1:0]   data_in;
  logic                      push;
  logic                      full;
  logic [$clog2(QDEPTH):0]   q_cnt;
  logic [7:0]                tx_byte;
  logic                      trmt;
  logic                      tx_done;
  logic [7:0]                rx_byte;
  logic                      rx_rdy;
  logic                      clr_rx_rdy;
  logic                      frm_snt;
  logic [7:0]                resp;
  logic [7:0]                resp_cmd;
  logic                      resp_vld;
  logic                      timeout;
  logic                      busy;

  modport master (
    input  cmd_in, data_in, push, tx_done, rx_byte, rx_rdy,
    output full, q_cnt, tx_byte, trmt, clr_rx_rdy, frm_snt,
           resp, resp_cmd, resp_vld, timeout, busy
  );

  modport slave (
    output cmd_in, data_in, push, tx_done, rx_byte, rx_rdy,
    input  full, q_cnt, tx_byte, trmt, clr_rx_rdy, frm_snt,
           resp, resp_cmd, resp_vld, timeout, busy
  );
endinterface

// File: rtl/cmd_frame_master.sv
// cmd_frame_master: queues host commands and sends each as a frame
// (command byte, then data bytes MSB-first) through a byte UART TX, then
// waits for a one-byte response, resending the frame on timeout.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   bus  - cmd_frame_if.master: host push side (cmd_in, data_in, push,
//          full, q_cnt), UART TX (tx_byte, trmt, tx_done), UART RX
//          (rx_byte, rx_rdy, clr_rx_rdy) and result/status outputs
//          (frm_snt, resp, resp_cmd, resp_vld, timeout, busy).
// All outputs are registered; next values are computed combinationally.
module cmd_frame_master #(
  parameter int DATA_BYTES  = 2,
  parameter int QDEPTH      = 4,
  parameter int TIMEOUT_CYC = 1_000_000,
  parameter int MAX_RETRY   = 2
) (
  input logic         clk,
  input logic         rst,
  cmd_frame_if.master bus
);

  localparam int FRAME_W = 8 * (DATA_BYTES + 1);
  localparam int DW      = 8 * DATA_BYTES;
  localparam int AW      = $clog2(QDEPTH);
  localparam int CW      = $clog2(QDEPTH) + 1;
  localparam int KW      = $clog2(DATA_BYTES + 1);
  localparam int TW      = $clog2(TIMEOUT_CYC);

  localparam logic [KW-1:0] K_LAST   = KW'(DATA_BYTES);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [2:0]    R_MAX    = 3'(MAX_RETRY);
  localparam logic [CW-1:0] CNT_FULL = CW'(QDEPTH);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_TX, WAIT_RESP} state_t;

  state_t state, state_nxt;

  // Command FIFO storage (data only, never reset)
  logic [7:0]    q_cmd  [QDEPTH];
  logic [DW-1:0] q_data [QDEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          push_ok, pop;

  // Frame being sent; kept intact so a retry can resend it unchanged
  logic [FRAME_W-1:0] frame, frame_nxt;
  logic [KW-1:0]      k, k_nxt;
  logic [2:0]         retry, retry_nxt;
  logic [TW-1:0]      tmr, tmr_nxt;

  logic [7:0] tx_byte_r, tx_byte_nxt;
  logic [7:0] resp_r, resp_nxt;
  logic [7:0] resp_cmd_r, resp_cmd_nxt;
  logic       trmt_r, trmt_nxt;
  logic       clr_r, clr_nxt;
  logic       frm_snt_r, frm_snt_nxt;
  logic       resp_vld_r, resp_vld_nxt;
  logic       timeout_r, timeout_nxt;
  logic       busy_r, full_r;

  // Byte idx of the frame, idx 0 being the command byte
  function automatic logic [7:0] frame_byte(input logic [FRAME_W-1:0] f,
                                            input logic [KW-1:0]      idx);
    logic [FRAME_W-1:0] sh;
    sh = f << {idx, 3'b000};
    return sh[FRAME_W-1 -: 8];
  endfunction

  // Saturating timer step: holds at all-ones instead of wrapping
  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // A push into a full FIFO is only taken when the head pops the same cycle
  assign push_ok = bus.push && ((cnt != CNT_FULL) || pop);
  assign cnt_nxt = cnt + CW'(push_ok) - CW'(pop);

  always_comb begin
    state_nxt    = state;
    frame_nxt    = frame;
    k_nxt        = k;
    retry_nxt    = retry;
    tmr_nxt      = tmr;
    tx_byte_nxt  = tx_byte_r;
    resp_nxt     = resp_r;
    resp_cmd_nxt = resp_cmd_r;
    trmt_nxt     = 1'b0;
    clr_nxt      = 1'b0;
    frm_snt_nxt  = 1'b0;
    resp_vld_nxt = 1'b0;
    timeout_nxt  = 1'b0;
    pop          = 1'b0;
    unique case (state)
      IDLE: begin
        if (cnt != '0) begin
          frame_nxt   = {q_cmd[rd_ptr], q_data[rd_ptr]};
          k_nxt       = '0;
          retry_nxt   = '0;
          tx_byte_nxt = q_cmd[rd_ptr];
          trmt_nxt    = 1'b1;
          clr_nxt     = 1'b1;   // flush any stale RX byte before a new frame
          state_nxt   = SEND;
        end
      end
      SEND: state_nxt = WAIT_TX;
      WAIT_TX: begin
        if (bus.tx_done) begin
          if (k < K_LAST) begin
            k_nxt       = k + 1'b1;
            tx_byte_nxt = frame_byte(frame, k + 1'b1);
            trmt_nxt    = 1'b1;
            state_nxt   = SEND;
          end else begin
            frm_snt_nxt = 1'b1;
            tmr_nxt     = '0;
            state_nxt   = WAIT_RESP;
          end
        end
      end
      WAIT_RESP: begin
        // Response is tested first so it wins over a same-cycle expiry
        if (bus.rx_rdy) begin
          resp_nxt     = bus.rx_byte;
          resp_cmd_nxt = frame[FRAME_W-1 -: 8];
          resp_vld_nxt = 1'b1;
          clr_nxt      = 1'b1;
          pop          = 1'b1;
          state_nxt    = IDLE;
        end else if (tmr == T_LAST) begin
          if (retry < R_MAX) begin
            retry_nxt   = retry + 1'b1;
            k_nxt       = '0;
            tx_byte_nxt = frame[FRAME_W-1 -: 8];
            trmt_nxt    = 1'b1;
            clr_nxt     = 1'b1;
            state_nxt   = SEND;
          end else begin
            timeout_nxt  = 1'b1;
            resp_nxt     = 8'h00;
            resp_cmd_nxt = frame[FRAME_W-1 -: 8];
            pop          = 1'b1;
            state_nxt    = IDLE;
          end
        end else begin
          tmr_nxt = sat_inc(tmr);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      k          <= '0;
      retry      <= '0;
      tmr        <= '0;
      tx_byte_r  <= '0;
      resp_r     <= '0;
      resp_cmd_r <= '0;
      trmt_r     <= 1'b0;
      clr_r      <= 1'b0;
      frm_snt_r  <= 1'b0;
      resp_vld_r <= 1'b0;
      timeout_r  <= 1'b0;
      busy_r     <= 1'b0;
      full_r     <= 1'b0;
    end else begin
      state      <= state_nxt;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      cnt        <= cnt_nxt;
      k          <= k_nxt;
      retry      <= retry_nxt;
      tmr        <= tmr_nxt;
      tx_byte_r  <= tx_byte_nxt;
      resp_r     <= resp_nxt;
      resp_cmd_r <= resp_cmd_nxt;
      trmt_r     <= trmt_nxt;
      clr_r      <= clr_nxt;
      frm_snt_r  <= frm_snt_nxt;
      resp_vld_r <= resp_vld_nxt;
      timeout_r  <= timeout_nxt;
      busy_r     <= (state_nxt != IDLE);
      full_r     <= (cnt_nxt == CNT_FULL);
    end
  end

  // Data registers
  always_ff @(posedge clk) begin
    frame <= frame_nxt;
    if (push_ok) begin
      q_cmd[wr_ptr]  <= bus.cmd_in;
      q_data[wr_ptr] <= bus.data_in;
    end
  end

  assign bus.full       = full_r;
  assign bus.q_cnt      = cnt;
  assign bus.tx_byte    = tx_byte_r;
  assign bus.trmt       = trmt_r;
  assign bus.clr_rx_rdy = clr_r;
  assign bus.frm_snt    = frm_snt_r;
  assign bus.resp       = resp_r;
  assign bus.resp_cmd   = resp_cmd_r;
  assign bus.resp_vld   = resp_vld_r;
  assign bus.timeout    = timeout_r;
  assign bus.busy       = busy_r;

endmodule
